note_sequence_player: RTL and testbench
=======================================

NOTE_SEQUENCE_PLAYER -- requirements
Module: note_sequence_player

Interface
REQ-001 Parameter GAP, default 2, meaning idle cycles between note strobes, legal range 0..7.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to play one word; sampled only in IDLE.
REQ-005 abort  input  1  cancel the word in progress; returns to IDLE.
REQ-006 tipo  input  2  word class to play: 00 null, 01 adjective, 10 complement, 11 adverb.
REQ-007 ok  output  1  one-cycle note-valid strobe.
REQ-008 nota  output  3  note code: 000 none, 001 do, 010 re, 011 mi, 100 fa, 101 sol, 110 la, 111 si.
REQ-009 tom  output  1  tone flag accompanying nota; 1 high, 0 low.
REQ-010 busy  output  1  high while a word is being played.
REQ-011 fim  output  1  one-cycle pulse after the last note of a word.
REQ-012 erro  output  1  one-cycle pulse when start arrives with tipo=00.
REQ-013 display  output  7  seven-segment code {a,b,c,d,e,f,g}, active-high, showing the last emitted nota value 0..7.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have states IDLE, EMIT, GAP, DONE and ERR.
REQ-016 IDLE with start=1 and tipo!=00 at edge N SHALL latch tipo, go to EMIT, and drive ok=1 with note 0 during cycle N+1.
REQ-017 IDLE with start=1 and tipo=00 SHALL go to ERR: erro=1 for one cycle, no ok, then return to IDLE.
REQ-018 Every word SHALL be 5 notes, as (tom,nota) pairs.
REQ-019 Adjective (01) SHALL be (1,do) (1,mi) (0,la) (0,si) (1,sol).
REQ-020 Complement (10) SHALL be (1,re) (0,la) (1,do) (1,re) (1,fa).
REQ-021 Adverb (11) SHALL be (1,mi) (0,la) (0,si) (1,do) (1,mi).
REQ-022 EMIT SHALL last one cycle, then GAP for exactly GAP cycles with ok=0, nota=000 and tom=0.
REQ-023 With GAP=0, the five notes SHALL occupy consecutive cycles.
REQ-024 Note period SHALL be GAP+1 cycles: note k strobes in cycle N+1+k(GAP+1).
REQ-025 After the 5th note's gap, the FSM SHALL enter DONE: fim=1 and busy=0 for one cycle, then IDLE.
REQ-026 fim SHALL be in cycle N+1+5(GAP+1).
REQ-027 busy SHALL be 1 from cycle N+1 through the last GAP cycle.
REQ-028 start SHALL be ignored outside IDLE, including in DONE and ERR.
REQ-029 A tipo change mid-word SHALL have no effect.
REQ-030 abort=1 in EMIT or GAP SHALL go to IDLE at the next edge, with ok=0, busy=0 and no fim.
REQ-031 abort SHALL take priority over every other transition.
REQ-032 abort and start together in IDLE SHALL produce no word.
REQ-033 The note index SHALL be 3 bits, counting 0..4, and SHALL clear on entering IDLE.
REQ-034 The gap counter SHALL be 3 bits, reload with GAP on EMIT, and never wrap.
REQ-035 display SHALL update only in EMIT, and hold the last value through GAP, DONE and IDLE.

Reset
REQ-036 reset=1 SHALL immediately, including mid-word, force state IDLE, note index 0, gap counter 0, ok=0, nota=000, tom=0, busy=0, fim=0, erro=0 and display=0000000 (blank).
REQ-037 After reset is released, start SHALL be honoured at the first posedge.

Structure
REQ-038 A shared package SHALL hold the note codes, tipo codes, FSM state encoding, and the nota-to-seven-segment function.
REQ-039 Sub-module note_pattern_rom SHALL be combinational, with inputs tipo[1:0] and idx[2:0], and outputs {tom,nota}.
REQ-040 note_pattern_rom SHALL return (0,000) for tipo=00 or idx>4.

Verification
REQ-041 GAP=2, start with tipo=01 at edge 0 -> ok in cycles 1,4,7,10,13 with nota 001,011,110,111,101 and tom 1,1,0,0,1; fim in cycle 16; busy over cycles 1..15.
REQ-042 GAP=0, tipo=11 -> ok in cycles 1..5 with nota 011,110,111,001,011; fim in cycle 6.
REQ-043 start with tipo=00 -> erro in cycle 1, no ok, busy stays 0; a start with tipo=10 in cycle 2 plays re,la,do,re,fa.
REQ-044 abort during the GAP after note 2 -> no further ok, no fim, busy=0 next cycle; display holds the note-2 code.
REQ-045 reset asserted asynchronously mid-EMIT -> all outputs zero before the next edge; start re-issued after release plays the full word.
REQ-046 start pulsed during busy and in the DONE cycle -> ignored; exactly one word and one fim are produced.

Source files
------------

// File: rtl/note_sequence_player_pkg.sv
// Shared definitions for the note sequence player: note/tipo codes, FSM encoding,
// note payload type and the nota-to-seven-segment decoder.
package note_sequence_player_pkg;

    localparam int unsigned NOTA_W   = 3;
    localparam int unsigned TIPO_W   = 2;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned ST_W     = 3;
    localparam int unsigned WORD_LEN = 5;

    // Note codes
    localparam logic [NOTA_W-1:0] NOTA_NONE = 3'd0;
    localparam logic [NOTA_W-1:0] NOTA_DO   = 3'd1;
    localparam logic [NOTA_W-1:0] NOTA_RE   = 3'd2;
    localparam logic [NOTA_W-1:0] NOTA_MI   = 3'd3;
    localparam logic [NOTA_W-1:0] NOTA_FA   = 3'd4;
    localparam logic [NOTA_W-1:0] NOTA_SOL  = 3'd5;
    localparam logic [NOTA_W-1:0] NOTA_LA   = 3'd6;
    localparam logic [NOTA_W-1:0] NOTA_SI   = 3'd7;

    // Word classes
    localparam logic [TIPO_W-1:0] TIPO_NULL = 2'b00;
    localparam logic [TIPO_W-1:0] TIPO_ADJ  = 2'b01;
    localparam logic [TIPO_W-1:0] TIPO_COMP = 2'b10;
    localparam logic [TIPO_W-1:0] TIPO_ADV  = 2'b11;

    // FSM state encoding
    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_EMIT = 3'd1;
    localparam logic [ST_W-1:0] ST_GAP  = 3'd2;
    localparam logic [ST_W-1:0] ST_DONE = 3'd3;
    localparam logic [ST_W-1:0] ST_ERR  = 3'd4;

    // One note of a word: tone flag plus note code
    typedef struct packed {
        logic              tom;
        logic [NOTA_W-1:0] nota;
    } note_t;

    // Active-high {a,b,c,d,e,f,g} pattern for the digit equal to the note code
    function automatic logic [SEG_W-1:0] nota_to_seg(input logic [NOTA_W-1:0] n);
        logic [SEG_W-1:0] seg;
        seg = '0;
        case (n)
            3'd0: seg = 7'b1111110;
            3'd1: seg = 7'b0110000;
            3'd2: seg = 7'b1101101;
            3'd3: seg = 7'b1111001;
            3'd4: seg = 7'b0110011;
            3'd5: seg = 7'b1011011;
            3'd6: seg = 7'b1011111;
            3'd7: seg = 7'b1110000;
            default: seg = '0;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/note_sequence_player_if.sv
// Control and note-output bundle between a word requester and the note player.
interface note_sequence_player_if;
    import note_sequence_player_pkg::*;

    logic              start;
    logic              abort;
    logic [TIPO_W-1:0] tipo;
    logic              ok;
    logic [NOTA_W-1:0] nota;
    logic              tom;
    logic              busy;
    logic              fim;
    logic              erro;
    logic [SEG_W-1:0]  display;

    modport master (
        output start, abort, tipo,
        input  ok, nota, tom, busy, fim, erro, display
    );

    modport slave (
        input  start, abort, tipo,
        output ok, nota, tom, busy, fim, erro, display
    );

endinterface

// File: rtl/note_pattern_rom.sv
// Combinational lookup of the k-th (tom,nota) pair of a word class; silent for
// the null class and for indices past the end of a word.
module note_pattern_rom
    import note_sequence_player_pkg::*;
(
    input  logic [TIPO_W-1:0] tipo_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic              tom_o,
    output logic [NOTA_W-1:0] nota_o
);

    note_t note;

    // Pattern table per word class
    always_comb begin
        note = '0;
        case (tipo_i)
            TIPO_ADJ: begin
                case (idx_i)
                    3'd0:    note = {1'b1, NOTA_DO};
                    3'd1:    note = {1'b1, NOTA_MI};
                    3'd2:    note = {1'b0, NOTA_LA};
                    3'd3:    note = {1'b0, NOTA_SI};
                    3'd4:    note = {1'b1, NOTA_SOL};
                    default: note = '0;
                endcase
            end
            TIPO_COMP: begin
                case (idx_i)
                    3'd0:    note = {1'b1, NOTA_RE};
                    3'd1:    note = {1'b0, NOTA_LA};
                    3'd2:    note = {1'b1, NOTA_DO};
                    3'd3:    note = {1'b1, NOTA_RE};
                    3'd4:    note = {1'b1, NOTA_FA};
                    default: note = '0;
                endcase
            end
            TIPO_ADV: begin
                case (idx_i)
                    3'd0:    note = {1'b1, NOTA_MI};
                    3'd1:    note = {1'b0, NOTA_LA};
                    3'd2:    note = {1'b0, NOTA_SI};
                    3'd3:    note = {1'b1, NOTA_DO};
                    3'd4:    note = {1'b1, NOTA_MI};
                    default: note = '0;
                endcase
            end
            default: note = '0;
        endcase
    end

    assign tom_o  = note.tom;
    assign nota_o = note.nota;

endmodule

// File: rtl/note_sequence_player.sv
// Plays one five-note word per start request, spacing note strobes by GAP idle
// cycles, then pulses fim. All outputs are registered from the next state.
module note_sequence_player
    import note_sequence_player_pkg::*;
#(
    parameter int unsigned GAP = 2
) (
    input logic                   clk,
    input logic                   reset,
    note_sequence_player_if.slave bus
);

    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);

    logic [ST_W-1:0]   state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [TIPO_W-1:0] tipo_q,  tipo_d;

    logic              ok_q,    ok_d;
    logic [NOTA_W-1:0] nota_q,  nota_d;
    logic              tom_q,   tom_d;
    logic              busy_q,  busy_d;
    logic              fim_q,   fim_d;
    logic              erro_q,  erro_d;
    logic [SEG_W-1:0]  disp_q,  disp_d;

    logic              rom_tom;
    logic [NOTA_W-1:0] rom_nota;

    // Note lookup for the note that will be strobed next cycle
    note_pattern_rom u_rom (
        .tipo_i (tipo_d),
        .idx_i  (idx_d),
        .tom_o  (rom_tom),
        .nota_o (rom_nota)
    );

    // Next-state logic: abort wins over everything, start honoured only in IDLE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tipo_d  = tipo_q;

        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.tipo == TIPO_NULL) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_EMIT;
                            tipo_d  = bus.tipo;
                            idx_d   = '0;
                        end
                    end
                end
                ST_EMIT: begin
                    if (GAP_LD != '0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LD;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_EMIT;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q > CNT_W'(1)) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_EMIT;
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                ST_ERR:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // Counters are always clean whenever the player sits in IDLE
        if (state_d == ST_IDLE) begin
            idx_d = '0;
            cnt_d = '0;
        end
    end

    // Output decode from the next state so every output is a flop
    always_comb begin
        ok_d   = (state_d == ST_EMIT);
        nota_d = ok_d ? rom_nota : NOTA_NONE;
        tom_d  = ok_d & rom_tom;
        busy_d = (state_d == ST_EMIT) || (state_d == ST_GAP);
        fim_d  = (state_d == ST_DONE);
        erro_d = (state_d == ST_ERR);
        disp_d = ok_d ? nota_to_seg(rom_nota) : disp_q;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tipo_q  <= TIPO_NULL;
            ok_q    <= 1'b0;
            nota_q  <= NOTA_NONE;
            tom_q   <= 1'b0;
            busy_q  <= 1'b0;
            fim_q   <= 1'b0;
            erro_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tipo_q  <= tipo_d;
            ok_q    <= ok_d;
            nota_q  <= nota_d;
            tom_q   <= tom_d;
            busy_q  <= busy_d;
            fim_q   <= fim_d;
            erro_q  <= erro_d;
            disp_q  <= disp_d;
        end
    end

    assign bus.ok      = ok_q;
    assign bus.nota    = nota_q;
    assign bus.tom     = tom_q;
    assign bus.busy    = busy_q;
    assign bus.fim     = fim_q;
    assign bus.erro    = erro_q;
    assign bus.display = disp_q;

endmodule

// File: tb/tb_note_sequence_player.sv
// Bench for note_sequence_player: two instances (GAP=2 and GAP=0) driven with the
// same directed and random stimulus, checked against a cycle-offset word model.
module tb_note_sequence_player;

    logic       clk;
    logic       reset;
    logic       start_r;
    logic       abort_r;
    logic [1:0] tipo_r;

    int n_checks = 0;
    int n_errors = 0;

    note_sequence_player_if bus2();
    note_sequence_player_if bus0();

    assign bus2.start = start_r;
    assign bus2.abort = abort_r;
    assign bus2.tipo  = tipo_r;
    assign bus0.start = start_r;
    assign bus0.abort = abort_r;
    assign bus0.tipo  = tipo_r;

    note_sequence_player #(.GAP(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    note_sequence_player #(.GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word tables as {tom, nota}, indexed [tipo][note]
    logic [3:0] pat [4][5] = '{
        '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
        '{4'b1001, 4'b1011, 4'b0110, 4'b0111, 4'b1101},
        '{4'b1010, 4'b0110, 4'b1001, 4'b1010, 4'b1100},
        '{4'b1011, 4'b0110, 4'b0111, 4'b1001, 4'b1011}
    };
    logic [6:0] seg [8] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70};

    // Model state per instance: index 0 is GAP=2, index 1 is GAP=0
    int         gp [2] = '{2, 0};
    int         age [2];      // cycle offset since the word's first note, -1 when idle
    logic       in_err [2];
    logic [1:0] wtipo [2];
    logic       e_ok [2];
    logic [2:0] e_nota [2];
    logic       e_tom [2];
    logic       e_busy [2];
    logic       e_fim [2];
    logic       e_erro [2];
    logic [6:0] e_disp [2];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            age[u] = -1; in_err[u] = 1'b0; wtipo[u] = 2'b00;
            e_ok[u] = 1'b0; e_nota[u] = 3'd0; e_tom[u] = 1'b0; e_busy[u] = 1'b0;
            e_fim[u] = 1'b0; e_erro[u] = 1'b0; e_disp[u] = 7'd0;
        end
    endtask

    task automatic model_emit(input int u, input logic [3:0] nt);
        e_ok[u]   = 1'b1;
        e_tom[u]  = nt[3];
        e_nota[u] = nt[2:0];
        e_disp[u] = seg[nt[2:0]];
    endtask

    // Expected outputs for the cycle after an edge that sampled (s, a, t)
    task automatic model_step(input int u, input logic s, input logic a, input logic [1:0] t);
        int period;
        int len;
        period = gp[u] + 1;
        len    = 5 * period;
        e_ok[u] = 1'b0; e_nota[u] = 3'd0; e_tom[u] = 1'b0;
        e_busy[u] = 1'b0; e_fim[u] = 1'b0; e_erro[u] = 1'b0;
        if (age[u] >= 0) begin
            if ((a && age[u] < len) || age[u] == len) begin
                age[u] = -1;
            end else begin
                age[u] = age[u] + 1;
                if (age[u] == len) begin
                    e_fim[u] = 1'b1;
                end else begin
                    e_busy[u] = 1'b1;
                    if (age[u] % period == 0)
                        model_emit(u, pat[wtipo[u]][age[u] / period]);
                end
            end
        end else if (in_err[u]) begin
            in_err[u] = 1'b0;
        end else if (s && !a) begin
            if (t == 2'b00) begin
                in_err[u] = 1'b1;
                e_erro[u] = 1'b1;
            end else begin
                wtipo[u]  = t;
                age[u]    = 0;
                e_busy[u] = 1'b1;
                model_emit(u, pat[t][0]);
            end
        end
    endtask

    task automatic compare_all();
        chk("g2.ok",      8'(bus2.ok),      8'(e_ok[0]));
        chk("g2.nota",    8'(bus2.nota),    8'(e_nota[0]));
        chk("g2.tom",     8'(bus2.tom),     8'(e_tom[0]));
        chk("g2.busy",    8'(bus2.busy),    8'(e_busy[0]));
        chk("g2.fim",     8'(bus2.fim),     8'(e_fim[0]));
        chk("g2.erro",    8'(bus2.erro),    8'(e_erro[0]));
        chk("g2.display", 8'(bus2.display), 8'(e_disp[0]));
        chk("g0.ok",      8'(bus0.ok),      8'(e_ok[1]));
        chk("g0.nota",    8'(bus0.nota),    8'(e_nota[1]));
        chk("g0.tom",     8'(bus0.tom),     8'(e_tom[1]));
        chk("g0.busy",    8'(bus0.busy),    8'(e_busy[1]));
        chk("g0.fim",     8'(bus0.fim),     8'(e_fim[1]));
        chk("g0.erro",    8'(bus0.erro),    8'(e_erro[1]));
        chk("g0.display", 8'(bus0.display), 8'(e_disp[1]));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at negedge
    task automatic cycle(input logic s, input logic a, input logic [1:0] t);
        start_r = s; abort_r = a; tipo_r = t;
        @(posedge clk);
        model_step(0, s, a, t);
        model_step(1, s, a, t);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)));
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock
    task automatic async_reset();
        start_r = 1'b0; abort_r = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        #1 compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_r = 1'b0; abort_r = 1'b0; tipo_r = 2'b00;
        model_reset();
        #2 compare_all();
        @(negedge clk);
        reset = 1'b0;

        // Adjective word right after reset release, tipo wiggling mid-word
        cycle(1'b1, 1'b0, 2'b01);
        idle(20);

        // Null word flags erro, then a complement word two cycles later
        cycle(1'b1, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 2'b00);
        cycle(1'b1, 1'b0, 2'b10);
        idle(18);

        // Adverb word aborted in the gap after note 2 of the GAP=2 player
        cycle(1'b1, 1'b0, 2'b11);
        idle(7);
        cycle(1'b0, 1'b1, 2'b11);
        idle(10);

        // Abort together with start in IDLE
        cycle(1'b1, 1'b1, 2'b10);
        idle(3);

        // Start pulses while busy and in the DONE cycle of the GAP=2 player
        cycle(1'b1, 1'b0, 2'b10);
        for (int i = 1; i <= 16; i++)
            cycle((i == 16) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)));
        idle(20);

        // Asynchronous reset during the first EMIT, then a full word
        cycle(1'b1, 1'b0, 2'b01);
        async_reset();
        cycle(1'b1, 1'b0, 2'b01);
        idle(20);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0),
                  2'($urandom_range(0, 3)));
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
